seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Consumer end of the 7-segment path on the Io board. Accepts a 4-digit hex value over a valid/ready load interface and holds it in shadow and active registers.
- Time-multiplexes the value onto the shared active-low io_sel/io_seg lines, inserting a blanking gap between digits to suppress ghosting.
- Sits in the board top between user logic and the io_sel/io_seg pins.

Parameters:
- DIGIT_TICKS, 100000, clocks each digit is driven (1 ms at 100 MHz); must be ≥2.
- BLANK_TICKS, 1000, clocks all digits are off between digits; must be ≥1.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- load_data  in  16  four hex nibbles; [3:0] is digit 0, the rightmost.
- load_dp  in  4  per-digit decimal point; 1 = lit.
- load_blank  in  4  per-digit blank; 1 = digit dark.
- load_valid  in  1  load request.
- load_ready  out  1  pending slot free.
- io_sel  out  4  digit enables, active-low; bit d selects digit d.
- io_seg  out  8  segments, active-low; [0]=a … [6]=g, [7]=dp.
- frame_start  out  1  one-cycle pulse when the active value is refreshed.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=BLANK, digit=0, tick counter=0.
  - Active value = 0, active dp = 0, active blank = 4'hF.
  - Pending slot empty.
  - Outputs: io_sel=4'hF, io_seg=8'hFF, load_ready=1, frame_start=0.
- Load handshake:
  - A transfer occurs when load_valid & load_ready on a clock edge. It captures data, dp and blank into the pending slot, sets pending_full, and drives load_ready=0 from the next cycle.
  - load_valid while load_ready=0 is ignored; the source holds its request.
- State machine (two states):
  - BLANK: counter runs 0..BLANK_TICKS-1. At the terminal count, go to DRIVE with counter=0.
  - DRIVE: counter runs 0..DIGIT_TICKS-1. At the terminal count, go to BLANK, counter=0, digit=(digit+1) mod 4.
- Registered outputs, updated on the same edge as the state change:
  - Entering DRIVE for digit d:
    - io_sel = ~(4'b0001<<d).
    - io_seg = active blank[d] ? 8'hFF : {~dp[d], hex_to_seg(nibble d)}.
  - Entering BLANK: io_sel=4'hF, io_seg=8'hFF.
- Frame boundary is the DRIVE→BLANK edge on which digit wraps 3→0. On that edge:
  - If pending_full: copy pending to active, clear pending_full, load_ready=1 on the next cycle, and pulse frame_start for one cycle.
  - If the slot is empty: active is unchanged and there is no pulse.
- Simultaneous capture and frame boundary on one edge: the newly captured value goes to pending only and becomes active at the following boundary. The transfer uses pending contents from before the edge.
- Display content never changes mid-frame, so there is no tearing.
- Frame period = 4·(DIGIT_TICKS+BLANK_TICKS) clocks. The first DRIVE of digit 0 begins BLANK_TICKS clocks after rst_n release.
- Decode table (active-low, dp excluded):
  - 0:C0, 1:F9, 2:A4, 3:B0
  - 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83
  - C:C6, d:A1, E:86, F:8E
- rst_n asserted mid-operation: immediate return to reset values; the pending value is discarded.

Optional Feature:
- Macro: SEG_BRIGHTNESS_EN.
- With the macro defined:
  - Extra input port brightness [2:0].
  - During DRIVE, segments are lit only while counter < ((brightness+1)·DIGIT_TICKS)>>3. For the rest of DRIVE, io_seg=8'hFF and io_sel stays asserted.
  - brightness is sampled at each BLANK→DRIVE edge.
  - brightness=7 is identical to the macro-off behaviour.
- Without the macro: no brightness port; segments are lit for the full DRIVE period.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS=4.
  - SEG_OFF=8'hFF, SEL_OFF=4'hF.
  - The 16-entry hex segment constant table.
  - The scan-state enum {BLANK, DRIVE}.
- One sub-module, hex_to_seg: purely combinational, 4-bit nibble in, 7-bit active-low pattern out, table from seg_pkg.

Test Plan (DIGIT_TICKS=10, BLANK_TICKS=2):
1. Reset mid-DRIVE of digit 2 → io_sel=F, io_seg=FF, load_ready=1 immediately (asynchronous); after release, sel=1110 appears 2 clocks later.
2. Load 16'h1A80, dp=4'b0100, blank=0 before the first boundary → next frame shows d0=C0, d1=80, d2=08 (88 with dp), d3=F9; frame_start pulses once.
3. Load 16'h1234, then a second load while load_ready=0 → the second request is ignored; after the boundary, load_ready=1 and a retry is accepted; the display shows 1234 and then the retried value one frame later.
4. Assert load_valid exactly on the 3→0 boundary edge with pending empty → frame_start=0 that edge; the value appears only after the next boundary with a pulse.
5. blank=4'b1000 → digit 3 drive slots show io_sel=0111, io_seg=FF; the other digits decode normally.
6. SEG_BRIGHTNESS_EN, brightness=1 → per DRIVE, segments are lit for 2 clocks and FF for 8; brightness=7 → lit for all 10 clocks.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: digit count, idle
// levels of the active-low pins, the hex segment table and the scan states.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SEL_OFF = 4'hF;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  // The decimal point bit is added separately by the driver.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load port of the scan driver: a value (four nibbles plus per-digit
// decimal point and blank flags) offered with valid/ready flow control.
interface seg_scan_driver_if;

  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_blank;
  logic        load_valid;
  logic        load_ready;

  modport master (
    output load_data, load_dp, load_blank, load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data, load_dp, load_blank, load_valid,
    output load_ready
  );

endinterface

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup; the table lives in the package.
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver. A loaded value waits in a pending
// slot and is promoted to the displayed value only at a frame boundary (the
// end of digit 3), so a frame is always drawn from one consistent value.
// Each digit is driven for DIGIT_TICKS clocks, separated by BLANK_TICKS
// clocks with every digit off to avoid ghosting between digits.
// Optional macro SEG_BRIGHTNESS_EN adds a 3-bit brightness input that
// shortens the lit portion of each drive slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   load,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [2:0]         brightness,
`endif
  output logic [3:0]         io_sel,
  output logic [7:0]         io_seg,
  output logic               frame_start
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  scan_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;

  logic [15:0] act_data_q, act_data_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [3:0]  act_blank_q, act_blank_d;

  logic [15:0] pend_data_q, pend_data_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [3:0]  pend_blank_q, pend_blank_d;
  logic        pend_full_q, pend_full_d;

  logic [3:0] io_sel_q, io_sel_d;
  logic [7:0] io_seg_q, io_seg_d;
  logic       frame_start_q, frame_start_d;

`ifdef SEG_BRIGHTNESS_EN
  logic [7:0]  seg_pat_q, seg_pat_d;
  logic [CW:0] thr_q, thr_d;
`endif

  logic [3:0] cur_nibble;
  logic [6:0] cur_hex;
  logic [7:0] cur_pat;
  logic       capture;

  // Pattern of the digit about to be driven, taken from the active value.
  always_comb begin
    cur_nibble = act_data_q[{digit_q, 2'b00} +: 4];
    cur_pat    = act_blank_q[digit_q] ? SEG_OFF : {~act_dp_q[digit_q], cur_hex};
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_hex)
  );

  assign load.load_ready = ~pend_full_q;
  assign io_sel          = io_sel_q;
  assign io_seg          = io_seg_q;
  assign frame_start     = frame_start_q;

  // Scan sequencing, output pins, frame-boundary promotion and load capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_full_d   = pend_full_q;
    io_sel_d      = io_sel_q;
    io_seg_d      = io_seg_q;
    frame_start_d = 1'b0;
`ifdef SEG_BRIGHTNESS_EN
    seg_pat_d     = seg_pat_q;
    thr_d         = thr_q;
`endif
    capture       = load.load_valid & ~pend_full_q;

    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_TICKS - 1)) begin
          state_d  = DRIVE;
          cnt_d    = '0;
          io_sel_d = ~(4'b0001 << digit_q);
`ifdef SEG_BRIGHTNESS_EN
          seg_pat_d = cur_pat;
          thr_d     = (CW+1)'(((32'(brightness) + 32'd1) * 32'(DIGIT_TICKS)) >> 3);
          io_seg_d  = (thr_d != '0) ? cur_pat : SEG_OFF;
`else
          io_seg_d  = cur_pat;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DRIVE: begin
        if (cnt_q == CW'(DIGIT_TICKS - 1)) begin
          state_d  = BLANK;
          cnt_d    = '0;
          digit_d  = digit_q + 2'd1;
          io_sel_d = SEL_OFF;
          io_seg_d = SEG_OFF;
          if ((digit_q == 2'(NUM_DIGITS - 1)) && pend_full_q) begin
            act_data_d    = pend_data_q;
            act_dp_d      = pend_dp_q;
            act_blank_d   = pend_blank_q;
            pend_full_d   = 1'b0;
            frame_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
`ifdef SEG_BRIGHTNESS_EN
          io_seg_d = ({1'b0, cnt_d} < thr_q) ? seg_pat_q : SEG_OFF;
`endif
        end
      end

      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    // Capture only happens with the slot empty, so it never collides with
    // a promotion; a capture on the boundary edge waits for the next frame.
    if (capture) begin
      pend_data_d  = load.load_data;
      pend_dp_d    = load.load_dp;
      pend_blank_d = load.load_blank;
      pend_full_d  = 1'b1;
    end
  end

  // State register; reset leaves the display dark and the slot empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      digit_q       <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= 4'hF;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_full_q   <= 1'b0;
      io_sel_q      <= SEL_OFF;
      io_seg_q      <= SEG_OFF;
      frame_start_q <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      seg_pat_q     <= SEG_OFF;
      thr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_full_q   <= pend_full_d;
      io_sel_q      <= io_sel_d;
      io_seg_q      <= io_seg_d;
      frame_start_q <= frame_start_d;
`ifdef SEG_BRIGHTNESS_EN
      seg_pat_q     <= seg_pat_d;
      thr_q         <= thr_d;
`endif
    end
  end

endmodule
